// File: rtl/aud_pkg.sv
// Shared audio package: playback FSM state type, Avalon register indices and
// CTRL/status bit positions used by the capture and playback blocks.
package aud_pkg;

    // Playback engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        READY = 2'd3
    } pb_state_t;

    // Avalon register indices
    localparam logic [2:0] REG_CTRL = 3'd0;
    localparam logic [2:0] REG_LEN  = 3'd1;
    localparam logic [2:0] REG_GAIN = 3'd2;
    localparam logic [2:0] REG_POS  = 3'd3;

    // CTRL write bit positions
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_LOOP_BIT  = 1;
    localparam int unsigned CTRL_STOP_BIT  = 2;

    // CTRL read (status) bit positions
    localparam int unsigned STAT_PLAYING_BIT  = 0;
    localparam int unsigned STAT_LOOP_BIT     = 1;
    localparam int unsigned STAT_DONE_BIT     = 2;
    localparam int unsigned STAT_UNDERRUN_BIT = 3;

endpackage

// File: rtl/aud_playback.sv
// aud_playback: Avalon-MM playback engine. Reads signed mono samples
// sequentially from the shared audio BRAM and presents one (attenuated)
// sample to both DAC channels on every advance pulse.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   chipselect/write/read/address/writedata/readdata - Avalon-MM slave
//   advance                       - one pulse per sample period from audio_driver
//   bram_ra / bram_data_out       - BRAM read port (1-cycle read latency)
//   dac_left / dac_right          - DAC samples (identical, mono)
//   playing                       - high while the engine is not IDLE
module aud_playback
    import aud_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [2:0]        address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              advance,
    output logic [ADDR_W-1:0] bram_ra,
    input  logic [DATA_W-1:0] bram_data_out,
    output logic [DATA_W-1:0] dac_left,
    output logic [DATA_W-1:0] dac_right,
    output logic              playing
);

    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

    pb_state_t         state_q,      state_d;
    logic [ADDR_W-1:0] pos_q,        pos_d;
    logic [ADDR_W-1:0] pos_out_q,    pos_out_d;
    logic [ADDR_W-1:0] len_q,        len_d;
    logic [ADDR_W-1:0] ra_q,         ra_d;
    logic [2:0]        gain_q,       gain_d;
    logic              loop_q,       loop_d;
    logic              done_q,       done_d;
    logic              underrun_q,   underrun_d;
    logic              playing_q,    playing_d;
    logic [DATA_W-1:0] sample_buf_q, sample_buf_d;
    logic [DATA_W-1:0] dac_q,        dac_d;
    logic [31:0]       readdata_q,   readdata_d;

    logic wr_s;
    logic rd_s;
    logic unused_wd_s;

    assign wr_s        = chipselect & write;
    assign rd_s        = chipselect & read;
    assign unused_wd_s = ^writedata[31:ADDR_W];

    // Arithmetic right shift keeps the sample sign (attenuation by 2^sh)
    function automatic logic [DATA_W-1:0] attenuate(input logic [DATA_W-1:0] smp,
                                                     input logic [2:0] sh);
        return $signed(smp) >>> sh;
    endfunction

    // Next-state: register read/clear, playback FSM, then register writes
    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        pos_out_d    = pos_out_q;
        len_d        = len_q;
        ra_d         = ra_q;
        gain_d       = gain_q;
        loop_d       = loop_q;
        done_d       = done_q;
        underrun_d   = underrun_q;
        sample_buf_d = sample_buf_q;
        dac_d        = dac_q;
        readdata_d   = 32'd0;

        // Read clears the sticky flags first so a same-cycle event still sets them
        if (rd_s) begin
            case (address)
                REG_CTRL: begin
                    readdata_d = {28'd0, underrun_q, done_q, loop_q, playing_q};
                    done_d     = 1'b0;
                    underrun_d = 1'b0;
                end
                REG_LEN:  readdata_d = 32'(len_q);
                REG_GAIN: readdata_d = {29'd0, gain_q};
                REG_POS:  readdata_d = 32'(pos_out_q);
                default:  readdata_d = 32'd0;
            endcase
        end else begin
            readdata_d = 32'd0;
        end

        case (state_q)
            IDLE: begin
                // Silence on the DAC once stopped or finished
                if (advance) begin
                    dac_d = '0;
                end else begin
                    dac_d = dac_q;
                end
            end
            FETCH: begin
                if (advance) begin
                    underrun_d = 1'b1;
                end else begin
                    underrun_d = underrun_d;
                end
                state_d = LOAD;
            end
            LOAD: begin
                if (advance) begin
                    underrun_d = 1'b1;
                end else begin
                    underrun_d = underrun_d;
                end
                sample_buf_d = bram_data_out;
                state_d      = READY;
            end
            READY: begin
                if (advance) begin
                    dac_d     = attenuate(sample_buf_q, gain_q);
                    pos_out_d = pos_q;
                    if (pos_q == len_q - ONE_A) begin
                        if (loop_q) begin
                            pos_d   = '0;
                            ra_d    = '0;
                            state_d = FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        pos_d   = pos_q + ONE_A;
                        ra_d    = ra_q + ONE_A;
                        state_d = FETCH;
                    end
                end else begin
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase

        // Register writes; STOP overrides START and any FSM transition
        if (wr_s) begin
            case (address)
                REG_CTRL: begin
                    loop_d = writedata[CTRL_LOOP_BIT];
                    if (writedata[CTRL_STOP_BIT]) begin
                        state_d = IDLE;
                    end else if (writedata[CTRL_START_BIT] && (state_q == IDLE)
                                 && (len_q != '0)) begin
                        state_d    = FETCH;
                        pos_d      = '0;
                        ra_d       = '0;
                        done_d     = 1'b0;
                        underrun_d = 1'b0;
                    end else begin
                        state_d = state_d;
                    end
                end
                REG_LEN: begin
                    if (state_q == IDLE) begin
                        len_d = writedata[ADDR_W-1:0];
                    end else begin
                        len_d = len_q;
                    end
                end
                REG_GAIN: gain_d = writedata[2:0];
                default:  gain_d = gain_q;
            endcase
        end else begin
            gain_d = gain_q;
        end

        playing_d = (state_d != IDLE);
    end

    // State and register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pos_q        <= '0;
            pos_out_q    <= '0;
            len_q        <= '0;
            ra_q         <= '0;
            gain_q       <= 3'd0;
            loop_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
            playing_q    <= 1'b0;
            sample_buf_q <= '0;
            dac_q        <= '0;
            readdata_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            pos_out_q    <= pos_out_d;
            len_q        <= len_d;
            ra_q         <= ra_d;
            gain_q       <= gain_d;
            loop_q       <= loop_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
            playing_q    <= playing_d;
            sample_buf_q <= sample_buf_d;
            dac_q        <= dac_d;
            readdata_q   <= readdata_d;
        end
    end

    assign readdata  = readdata_q;
    assign bram_ra   = ra_q;
    assign dac_left  = dac_q;
    assign dac_right = dac_q;
    assign playing   = playing_q;

endmodule

// File: tb/tb_aud_playback.sv
// Directed self-checking bench for aud_playback with a 1-cycle-latency BRAM model.
module tb_aud_playback;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        advance;
    logic [15:0] bram_ra;
    logic [23:0] bram_data_out;
    logic [23:0] dac_left;
    logic [23:0] dac_right;
    logic        playing;

    logic [23:0] mem [0:15];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Registered BRAM read port
    always @(posedge clk) bram_data_out <= mem[bram_ra[3:0]];

    aud_playback #(.ADDR_W(16), .DATA_W(24)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata),
        .readdata(readdata), .advance(advance), .bram_ra(bram_ra),
        .bram_data_out(bram_data_out), .dac_left(dac_left),
        .dac_right(dac_right), .playing(playing)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick(1);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick(1);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic adv();
        advance = 1'b1;
        tick(1);
        advance = 1'b0;
    endtask

    // Pulse advance and check both DAC channels
    task automatic adv_chk(input string tag, input logic [23:0] exp);
        adv();
        chk({tag, "_L"}, {8'd0, dac_left}, {8'd0, exp});
        chk({tag, "_R"}, {8'd0, dac_right}, {8'd0, exp});
    endtask

    logic [31:0] rdv;
    logic [23:0] exp_plain [0:3];
    logic [23:0] exp_g2 [0:3];

    initial begin
        mem[0] = 24'h000010; mem[1] = 24'hFFFFF0; mem[2] = 24'h7FFFFF; mem[3] = 24'h800000;
        for (int i = 4; i < 16; i++) mem[i] = 24'h0;
        exp_plain[0] = 24'h000010; exp_plain[1] = 24'hFFFFF0;
        exp_plain[2] = 24'h7FFFFF; exp_plain[3] = 24'h800000;
        exp_g2[0] = 24'h000004; exp_g2[1] = 24'hFFFFFC;
        exp_g2[2] = 24'h1FFFFF; exp_g2[3] = 24'hE00000;

        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = 3'd0; writedata = 32'd0; advance = 1'b0;
        tick(3);
        reset = 1'b0;
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_bram_ra", {16'd0, bram_ra}, 32'd0);
        chk("rst_dac", {8'd0, dac_left}, 32'd0);
        chk("rst_playing", {31'd0, playing}, 32'd0);

        // One-shot playback of 4 samples
        wr(3'd1, 32'd4);
        wr(3'd0, 32'h1);
        chk("os_playing", {31'd0, playing}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(19);
            adv_chk($sformatf("os%0d", i), exp_plain[i]);
            if (i == 1) begin
                rd(3'd3, rdv);
                chk("os_pos", rdv, 32'd1);
            end
        end
        chk("os_done_playing", {31'd0, playing}, 32'd0);
        tick(19);
        adv_chk("os_silence", 24'h0);
        rd(3'd0, rdv);
        chk("os_ctrl_done", rdv, 32'h4);
        rd(3'd0, rdv);
        chk("os_ctrl_clr", rdv, 32'h0);

        // Looped playback, 10 samples
        wr(3'd0, 32'h3);
        for (int i = 0; i < 10; i++) begin
            tick(19);
            adv_chk($sformatf("lp%0d", i), exp_plain[i % 4]);
            chk($sformatf("lp_play%0d", i), {31'd0, playing}, 32'd1);
        end
        rd(3'd0, rdv);
        chk("lp_ctrl", rdv, 32'h3);
        wr(3'd0, 32'h4);
        chk("lp_stop_playing", {31'd0, playing}, 32'd0);
        tick(5);
        adv_chk("lp_silence", 24'h0);

        // GAIN=2; LENGTH write while playing must be ignored
        wr(3'd2, 32'd2);
        wr(3'd0, 32'h1);
        wr(3'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(19);
            adv_chk($sformatf("g2_%0d", i), exp_g2[i]);
        end
        rd(3'd0, rdv);
        chk("g2_ctrl_done", rdv, 32'h4);

        // Underrun with GAIN=1, then STOP after 2 samples
        wr(3'd2, 32'd1);
        adv_chk("ur_pre", 24'h0);
        wr(3'd0, 32'h1);
        adv_chk("ur_hold", 24'h0);
        tick(5);
        adv_chk("ur_s0", 24'h000008);
        rd(3'd0, rdv);
        chk("ur_ctrl", rdv, 32'h9);
        rd(3'd0, rdv);
        chk("ur_ctrl_clr", rdv, 32'h1);
        tick(10);
        adv_chk("ur_s1", 24'hFFFFF8);
        wr(3'd0, 32'h4);
        chk("stop_playing", {31'd0, playing}, 32'd0);
        adv_chk("stop_silence", 24'h0);
        rd(3'd3, rdv);
        chk("stop_pos", rdv, 32'd1);

        // START with LENGTH=0 is ignored
        wr(3'd1, 32'd0);
        wr(3'd0, 32'h1);
        chk("len0_playing", {31'd0, playing}, 32'd0);
        tick(2);
        chk("len0_playing2", {31'd0, playing}, 32'd0);

        // Reset during READY, then replay from address 0
        wr(3'd1, 32'd4);
        wr(3'd2, 32'd0);
        wr(3'd0, 32'h1);
        tick(5);
        adv_chk("rr_s0", 24'h000010);
        tick(5);
        reset = 1'b1;
        tick(1);
        chk("rr_dac", {8'd0, dac_left}, 32'd0);
        chk("rr_bram_ra", {16'd0, bram_ra}, 32'd0);
        chk("rr_playing", {31'd0, playing}, 32'd0);
        chk("rr_readdata", readdata, 32'd0);
        reset = 1'b0;
        rd(3'd0, rdv);
        chk("rr_ctrl", rdv, 32'h0);
        wr(3'd1, 32'd1);
        wr(3'd0, 32'h1);
        chk("rr_start_ra", {16'd0, bram_ra}, 32'd0);
        tick(5);
        adv_chk("rr_replay", 24'h000010);
        chk("rr_end_playing", {31'd0, playing}, 32'd0);
        rd(3'd3, rdv);
        chk("rr_pos", rdv, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
